// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage to req/ack data-bus bridge with pipeline stall
// Optional bus timeout: define MEM_BUS_TIMEOUT_EN.   Revision: 1.0
// ============================================================================
module mem_access_unit #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   input  logic                  mem_en,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_stall,
   output logic                  mem_misalign,
   output logic                  mem_err,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   output logic [31:0]           stall_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

   logic [1:0]            state;
   logic [1:0]            next_state;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  access;
   logic                  aligned;
   logic                  issue;
   logic                  timeout;
   logic                  finish;

   assign access  = mem_ren | mem_wen;
   assign aligned = (mem_addr[1:0] == 2'b00);
   assign issue   = (state == ST_IDLE) && access && aligned;
   assign finish  = (state == ST_BUSY) && (bus_ack || timeout);

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WAIT_W-1:0] wait_cnt;
   logic              err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (issue) begin
         wait_cnt <= '0;
      end else if (state == ST_BUSY) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // An ack on the final allowed edge still wins over the timeout.
   assign timeout = (state == ST_BUSY) && !bus_ack &&
                    (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (timeout) begin
         err_q <= 1'b1;
      end else if ((state == ST_DONE) && mem_en) begin
         err_q <= 1'b0;
      end
   end

   assign mem_err = err_q;
`else
   assign timeout = 1'b0;
   assign mem_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (issue)  next_state = ST_BUSY;
         ST_BUSY: if (finish) next_state = ST_DONE;
         ST_DONE: if (mem_en) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_stall    = 1'b0;
      mem_misalign = 1'b0;
      mem_din      = rdata_q;
      case (state)
         ST_IDLE: begin
            if (access) begin
               if (aligned) begin
                  mem_stall = 1'b1;
               end else begin
                  mem_misalign = 1'b1;
                  mem_din      = '0;
               end
            end
         end
         ST_BUSY: mem_stall = 1'b1;
         default: ;
      endcase
   end

   // A store that is also flagged as a load never updates the read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         rdata_q   <= '0;
      end else if (issue) begin
         bus_req   <= 1'b1;
         bus_we    <= mem_wen;
         bus_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
         bus_wdata <= mem_dout;
      end else if (finish) begin
         bus_req <= 1'b0;
         if (!bus_we) begin
            rdata_q <= bus_ack ? bus_rdata : ERR_DATA;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if (mem_stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// tb_mem_access_unit : transaction-scheduled expectations checked every cycle,
// plus literal checks for the directed access scenarios.
module tb_mem_access_unit;

`ifdef MEM_BUS_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 64;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ren, mem_wen, mem_en;
   logic [31:0] mem_addr, mem_dout;
   logic [31:0] mem_din;
   logic        mem_stall, mem_misalign, mem_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [31:0] stall_count;

   mem_access_unit #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_en(mem_en),
      .mem_din(mem_din), .mem_stall(mem_stall), .mem_misalign(mem_misalign),
      .mem_err(mem_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Expected per-cycle values, set by the stimulus from the transaction schedule
   logic        exp_stall = 1'b0, exp_misalign = 1'b0;
   logic [31:0] exp_din = '0;
   logic        din_chk = 1'b1;
   logic        m_req = 1'b0, m_we = 1'b0, m_err = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   logic [31:0] m_count;
   logic        checking = 1'b0;

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   // Stall-cycle count is simply the number of cycles expected to stall
   always @(posedge clk or posedge rst) begin
      if (rst) m_count <= '0;
      else if (exp_stall && (m_count != 32'hFFFF_FFFF)) m_count <= m_count + 32'd1;
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("stall", {31'd0, mem_stall}, {31'd0, exp_stall});
         chk("misalign", {31'd0, mem_misalign}, {31'd0, exp_misalign});
         if (din_chk) chk("din", mem_din, exp_din);
         chk("bus_req", {31'd0, bus_req}, {31'd0, m_req});
         chk("bus_we", {31'd0, bus_we}, {31'd0, m_we});
         chk("bus_addr", bus_addr, m_addr);
         chk("bus_wdata", bus_wdata, m_wdata);
         chk("err", {31'd0, mem_err}, {31'd0, m_err});
         chk("stall_count", stall_count, m_count);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle_expect();
      mem_ren = 1'b0; mem_wen = 1'b0;
      exp_stall = 1'b0; exp_misalign = 1'b0; exp_din = m_rdata; din_chk = 1'b1;
   endtask

   task automatic idle_cycle(input bit rand_ack);
      set_idle_expect();
      mem_addr  = $urandom;
      mem_en    = 1'($urandom);
      bus_ack   = rand_ack ? 1'($urandom) : 1'b0;
      bus_rdata = $urandom;
      next_cycle();
      bus_ack = 1'b0;
   endtask

   // One MEM-stage access: lat = BUSY cycles until ack, hold = extra DONE cycles
   task automatic do_access(input bit ren, input bit wen, input logic [31:0] addr,
                            input logic [31:0] dout, input logic [31:0] rdata,
                            input int lat, input int hold, input bit no_ack);
      bit is_read;
      is_read   = ren && !wen;
      mem_ren   = ren; mem_wen = wen; mem_addr = addr; mem_dout = dout;
      mem_en    = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
      din_chk   = 1'b1; m_err = 1'b0;
      if (addr[1:0] != 2'b00) begin
         exp_stall = 1'b0; exp_misalign = 1'b1; exp_din = '0;
         next_cycle();
         set_idle_expect();
         return;
      end
      exp_stall = 1'b1; exp_misalign = 1'b0; exp_din = m_rdata;
      next_cycle();
      m_req = 1'b1; m_we = wen; m_addr = {addr[31:2], 2'b00}; m_wdata = dout;
      din_chk = 1'b0;
      for (int i = 1; i <= lat; i++) begin
         if (i == lat && !no_ack) begin
            bus_ack = 1'b1; bus_rdata = rdata;
         end
         next_cycle();
      end
      bus_ack = 1'b0; m_req = 1'b0; din_chk = 1'b1; exp_stall = 1'b0;
      if (is_read) m_rdata = no_ack ? 32'hDEAD_BEEF : rdata;
      if (no_ack) m_err = 1'b1;
      exp_din = m_rdata;
      for (int h = 0; h <= hold; h++) begin
         mem_en = (h == hold);
         if (no_ack && h == 0) begin
            #1;
            chk("timeout_err", {31'd0, mem_err}, 32'd1);
            chk("timeout_din", mem_din, 32'hDEAD_BEEF);
         end
         next_cycle();
      end
      mem_en = 1'b0; m_err = 1'b0;
      set_idle_expect();
   endtask

   initial begin
      int  kind;
      int  maxlat;
      logic [31:0] a;
      rst = 1'b1; mem_ren = 1'b0; mem_wen = 1'b0; mem_en = 1'b0;
      mem_addr = '0; mem_dout = '0; bus_ack = 1'b0; bus_rdata = '0;
      #12;
      chk("rst_req", {31'd0, bus_req}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_din", mem_din, 32'd0);
      chk("rst_count", stall_count, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      checking = 1'b1;
      idle_cycle(0);

      // Read with ack on the third BUSY edge
      do_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 3, 0, 1'b0);
      chk("rd_count", stall_count, 32'd4);
      chk("rd_addr", bus_addr, 32'h10);
      chk("rd_we", {31'd0, bus_we}, 32'd0);
      chk("rd_din", mem_din, 32'h1234_5678);

      // Write with ack on the first BUSY edge
      do_access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h9999_9999, 1, 0, 1'b0);
      chk("wr_we", {31'd0, bus_we}, 32'd1);
      chk("wr_wdata", bus_wdata, 32'hCAFE_0001);
      chk("wr_count", stall_count, 32'd6);
      chk("wr_din_kept", mem_din, 32'h1234_5678);

      // Misaligned read
      mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h13; mem_en = 1'b1;
      exp_stall = 1'b0; exp_misalign = 1'b1; exp_din = '0;
      #1;
      chk("mis_flag", {31'd0, mem_misalign}, 32'd1);
      chk("mis_stall", {31'd0, mem_stall}, 32'd0);
      chk("mis_din", mem_din, 32'd0);
      next_cycle();
      set_idle_expect();
      chk("mis_noreq", {31'd0, bus_req}, 32'd0);
      chk("mis_count", stall_count, 32'd6);

      // Read that completes while the pipeline is held elsewhere
      do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0F0F, 2, 3, 1'b0);
      chk("hold_din", mem_din, 32'hA5A5_0F0F);
      chk("hold_count", stall_count, 32'd9);

      // Load+store flagged together behaves as a store
      do_access(1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 32'h1111_1111, 2, 1, 1'b0);
      chk("both_we", {31'd0, bus_we}, 32'd1);
      chk("both_din", mem_din, 32'hA5A5_0F0F);

`ifdef MEM_BUS_TIMEOUT_EN
      do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 32'h0, TO, 0, 1'b1);
      chk("to_din_after", mem_din, 32'hDEAD_BEEF);
      chk("to_err_cleared", {31'd0, mem_err}, 32'd0);
`endif

      maxlat = (TO < 6) ? TO : 6;
      repeat (60) begin
         repeat ($urandom_range(0, 2)) idle_cycle(1);
         kind = $urandom_range(0, 2);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         do_access(kind != 1, kind != 0, a, $urandom, $urandom,
                   $urandom_range(1, maxlat), $urandom_range(0, 3), 1'b0);
      end
      idle_cycle(0);

      // Asynchronous reset in the middle of a BUSY wait
      mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h80; mem_dout = 32'h7777_0000;
      bus_ack = 1'b0; exp_stall = 1'b1; exp_misalign = 1'b0; exp_din = m_rdata;
      next_cycle();
      m_req = 1'b1; m_we = 1'b0; m_addr = 32'h80; m_wdata = 32'h7777_0000; din_chk = 1'b0;
      next_cycle();
      #2;
      checking = 1'b0;
      rst = 1'b1; mem_ren = 1'b0;
      #1;
      chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
      chk("rst_mid_count", stall_count, 32'd0);
      chk("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_mid_din", mem_din, 32'd0);
      m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
      set_idle_expect();
      @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      checking = 1'b1;
      bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
      next_cycle();
      bus_ack = 1'b0;
      chk("late_ack_req", {31'd0, bus_req}, 32'd0);
      chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
      chk("late_ack_din", mem_din, 32'd0);
      idle_cycle(0);
      idle_cycle(0);

      checking = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the pipeline datapath's MEM stage. Consumes `mem_ren`, `mem_wen`, `mem_addr` and `mem_dout`, and returns `mem_din`.
- Converts each single-cycle MEM-stage access into a req/ack transaction on a variable-latency data-memory bus.
- Raises `mem_stall` so the hazard controller freezes the pipeline until the access completes.
- Keeps a stall-cycle counter for performance debug.

Parameters:
- ADDR_WIDTH, 32, width of `mem_addr` and `bus_addr`.
- DATA_WIDTH, 32, width of all data ports.
- TIMEOUT_CYCLES, 64, bus wait limit in cycles; used only with MEM_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  main clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_ren  in  1  MEM-stage read enable.
- mem_wen  in  1  MEM-stage write enable.
- mem_addr  in  ADDR_WIDTH  MEM-stage byte address (ALU result).
- mem_dout  in  DATA_WIDTH  store data from the datapath.
- mem_en  in  1  MEM stage advances at this edge (from the hazard controller).
- mem_din  out  DATA_WIDTH  load data to the datapath.
- mem_stall  out  1  pipeline must hold; combinational.
- mem_misalign  out  1  current access is not word-aligned; combinational.
- mem_err  out  1  bus timeout on the current access.
- bus_req  out  1  bus request; registered.
- bus_we  out  1  bus write strobe; registered.
- bus_addr  out  ADDR_WIDTH  word-aligned bus address; registered.
- bus_wdata  out  DATA_WIDTH  bus write data; registered.
- bus_ack  in  1  bus completion, sampled at clk.
- bus_rdata  in  DATA_WIDTH  bus read data, valid with `bus_ack`.
- stall_count  out  32  saturating count of cycles with `mem_stall`=1.

Behaviour:
- Reset values: state=IDLE. `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `rdata_q`, `mem_err`, `stall_count` are all 0. `mem_din`=0.
- Reset mid-transaction drops `bus_req` immediately. A late `bus_ack` seen in IDLE is ignored.
- access = `mem_ren` | `mem_wen`. If both are set, treat as a write with no read data (`rdata_q` unchanged).
- IDLE, access=1 and `mem_addr[1:0]`==0:
  - `mem_stall`=1 combinationally.
  - At the edge: `bus_req`<=1, `bus_we`<=`mem_wen`, `bus_addr`<={`mem_addr`[ADDR_WIDTH-1:2],2'b00}, `bus_wdata`<=`mem_dout`.
  - Next state: BUSY.
- IDLE, access=1 and misaligned:
  - `mem_misalign`=1, `mem_stall`=0, no bus request.
  - `mem_din`=0; the access completes in zero extra cycles.
- IDLE, access=0: `mem_stall`=0, `mem_din`=`rdata_q`.
- BUSY:
  - `mem_stall`=1; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` held constant.
  - On `bus_ack`=1 at an edge: `rdata_q`<=`bus_rdata` if read, `bus_req`<=0, next state DONE.
- DONE:
  - `mem_stall`=0, `mem_din`=`rdata_q`.
  - If `mem_en`=1, go to IDLE. The next MEM-stage instruction is evaluated in IDLE one cycle later, so back-to-back memory accesses cost ≥2 cycles each.
  - If `mem_en`=0 (another hazard stalls), stay in DONE holding `mem_din`. No new request is issued for the same access.
- Minimum latency: 1 stall cycle in IDLE, plus N BUSY cycles, plus 1 DONE cycle, where `bus_ack` is seen on the N-th BUSY edge.
- `stall_count` increments every cycle with `mem_stall`=1 and saturates at 32'hFFFF_FFFF.
- `mem_err` is cleared on entering IDLE.

Optional Feature:
MEM_BUS_TIMEOUT_EN
- Defined:
  - An 8-bit or larger wait counter clears on entering BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES without `bus_ack`: `bus_req`<=0, `rdata_q`<=32'hDEAD_BEEF (reads only), `mem_err`<=1, next state DONE.
  - `mem_err` stays high through DONE.
- Undefined:
  - No counter is built; BUSY waits forever.
  - `mem_err` is tied to 0.

Test Plan:
- Read, ack after 3 BUSY cycles:
  - Stimulus: `mem_ren`=1, `mem_addr`=0x0000_0010, `bus_rdata`=0x1234_5678.
  - Response: `bus_addr`=0x10, `bus_we`=0, `mem_stall` high 4 cycles; in DONE `mem_din`=0x1234_5678; `stall_count`=4.
- Write, ack after 1 BUSY cycle:
  - Stimulus: `mem_wen`=1, `mem_addr`=0x20, `mem_dout`=0xCAFE_0001.
  - Response: `bus_we`=1, `bus_wdata`=0xCAFE_0001, `mem_stall` high 2 cycles; `rdata_q` unchanged.
- Misaligned read:
  - Stimulus: `mem_ren`=1, `mem_addr`=0x13.
  - Response: `mem_misalign`=1, `mem_stall`=0, `bus_req` never asserted, `mem_din`=0.
- DONE hold:
  - Stimulus: read completes while `mem_en`=0 for 3 cycles.
  - Response: state stays DONE, `mem_din` stable, `bus_req`=0 throughout; IDLE after `mem_en`=1.
- Reset mid-BUSY:
  - Stimulus: assert `rst` asynchronously, then send `bus_ack` after release.
  - Response: `bus_req`=0 immediately, `stall_count`=0, ack ignored, `mem_stall`=0.
- Timeout (MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: read with no `bus_ack`.
  - Response: after 4 BUSY cycles `mem_err`=1 and `mem_din`=0xDEAD_BEEF in DONE.
